// File: rtl/alu_operand_fetch.sv
// -----------------------------------------------------------------------------
// alu_operand_fetch
//
// Registered operand-fetch stage between the register file and the ALU.
// Operand A and B sources are chosen with one-hot selects. If more than one
// bit is set, the lowest set bit wins. B can take an immediate instead of a
// register. A writeback in the same cycle is forwarded into the captured pair.
// The pair is held in a one-entry valid/ready buffer. While the pair waits for
// the ALU, a writeback to a held operand's source register refreshes that
// operand, so the ALU never sees a stale value.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req_valid in   fetch request present
//   req_ready out  stage can accept a request (also true on the consume cycle)
//   sel_a     in   [NREG]   A source select, lowest set bit wins
//   sel_b     in   [NREG]   B source select, lowest set bit wins
//   imm_en_b  in   B takes imm instead of a register
//   imm       in   [DATA_W] immediate for B
//   rf_data   in   [NREG*DATA_W] register i at bits [i*DATA_W +: DATA_W]
//   wb_valid  in   register write this cycle
//   wb_sel    in   [NREG]   write target, lowest set bit wins, zero = no write
//   wb_data   in   [DATA_W] write data
//   op_valid  out  da/db hold a valid pair
//   op_ready  in   ALU consumes the pair
//   da, db    out  [DATA_W] operands
//   op_err    out  held pair had an empty select
// -----------------------------------------------------------------------------
module alu_operand_fetch #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NREG-1:0]          sel_a,
    input  logic [NREG-1:0]          sel_b,
    input  logic                     imm_en_b,
    input  logic [DATA_W-1:0]        imm,
    input  logic [NREG*DATA_W-1:0]   rf_data,
    input  logic                     wb_valid,
    input  logic [NREG-1:0]          wb_sel,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [DATA_W-1:0]        da,
    output logic [DATA_W-1:0]        db,
    output logic                     op_err
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Index of the lowest set bit. The caller qualifies the result with |v,
    // so an all-zero vector can safely return 0 here.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREG-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Register file unpacking
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_word [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf_unpack
            assign rf_word[gi] = rf_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Source decode and forwarding for the incoming request
    // ------------------------------------------------------------------
    logic             a_any;
    logic             b_any;
    logic [IDX_W-1:0] a_idx;
    logic [IDX_W-1:0] b_idx;
    logic             wb_hit;
    logic [IDX_W-1:0] wb_idx;
    logic             b_from_reg;
    logic [DATA_W-1:0] a_value;
    logic [DATA_W-1:0] b_value;
    logic             req_err;

    assign a_any  = |sel_a;
    assign b_any  = |sel_b;
    assign a_idx  = lowest_idx(sel_a);
    assign b_idx  = lowest_idx(sel_b);
    // An all-zero wb_sel means no write, even if wb_valid is high.
    assign wb_hit = wb_valid & (|wb_sel);
    assign wb_idx = lowest_idx(wb_sel);

    // When the immediate is used, B has no register source.
    assign b_from_reg = ~imm_en_b & b_any;

    always_comb begin
        a_value = '0;
        if (a_any) begin
            a_value = (wb_hit && (wb_idx == a_idx)) ? wb_data : rf_word[a_idx];
        end
    end

    always_comb begin
        b_value = '0;
        if (imm_en_b) begin
            b_value = imm;
        end else if (b_any) begin
            b_value = (wb_hit && (wb_idx == b_idx)) ? wb_data : rf_word[b_idx];
        end
    end

    // The immediate can never be empty, so an empty sel_b only counts as an
    // error when B comes from a register.
    assign req_err = ~a_any | (~b_any & ~imm_en_b);

    // ------------------------------------------------------------------
    // Output buffer state
    // ------------------------------------------------------------------
    state_t            state_reg,     state_next;
    logic [DATA_W-1:0] da_reg,        da_next;
    logic [DATA_W-1:0] db_reg,        db_next;
    logic              op_err_reg,    op_err_next;
    logic [IDX_W-1:0]  a_idx_reg,     a_idx_next;
    logic [IDX_W-1:0]  b_idx_reg,     b_idx_next;
    logic              has_src_a_reg, has_src_a_next;
    logic              has_src_b_reg, has_src_b_next;

    logic capture;
    logic refresh_a;
    logic refresh_b;

    // The stage can accept a request on the same cycle the ALU drains it.
    assign req_ready = (state_reg == EMPTY) | op_ready;
    assign capture   = req_valid & req_ready;

    // Refresh only applies to a pair that stays held: it must be valid, not
    // consumed and not replaced. Empty selects and the immediate never have
    // has_src set, so they never refresh.
    assign refresh_a = has_src_a_reg & wb_hit & (wb_idx == a_idx_reg);
    assign refresh_b = has_src_b_reg & wb_hit & (wb_idx == b_idx_reg);

    always_comb begin
        state_next     = state_reg;
        da_next        = da_reg;
        db_next        = db_reg;
        op_err_next    = op_err_reg;
        a_idx_next     = a_idx_reg;
        b_idx_next     = b_idx_reg;
        has_src_a_next = has_src_a_reg;
        has_src_b_next = has_src_b_reg;

        if (capture) begin
            // A new pair always overrides any refresh of the old one.
            state_next     = FULL;
            da_next        = a_value;
            db_next        = b_value;
            op_err_next    = req_err;
            a_idx_next     = a_idx;
            b_idx_next     = b_idx;
            has_src_a_next = a_any;
            has_src_b_next = b_from_reg;
        end else if (state_reg == FULL) begin
            if (op_ready) begin
                // When the pair is consumed, the data registers keep their
                // contents. They are meaningless until the next capture.
                state_next = EMPTY;
            end else begin
                if (refresh_a) begin
                    da_next = wb_data;
                end
                if (refresh_b) begin
                    db_next = wb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            da_reg        <= '0;
            db_reg        <= '0;
            op_err_reg    <= 1'b0;
            a_idx_reg     <= '0;
            b_idx_reg     <= '0;
            has_src_a_reg <= 1'b0;
            has_src_b_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            da_reg        <= da_next;
            db_reg        <= db_next;
            op_err_reg    <= op_err_next;
            a_idx_reg     <= a_idx_next;
            b_idx_reg     <= b_idx_next;
            has_src_a_reg <= has_src_a_next;
            has_src_b_reg <= has_src_b_next;
        end
    end

    assign op_valid = (state_reg == FULL);
    assign da       = da_reg;
    assign db       = db_reg;
    assign op_err   = op_err_reg;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// -----------------------------------------------------------------------------
// Testbench for alu_operand_fetch. One instance uses the default 8-bit /
// 4-register configuration. A second instance uses 16 bits / 8 registers.
// The narrow instance is tracked by a behavioural model of the held pair.
// -----------------------------------------------------------------------------
module tb_alu_operand_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit / 4-register instance
    logic        req_valid, req_ready, imm_en_b, wb_valid, op_valid, op_ready, op_err;
    logic [3:0]  sel_a, sel_b, wb_sel;
    logic [7:0]  imm, wb_data, da, db;
    logic [31:0] rf_data;

    // 16-bit / 8-register instance
    logic         w_req_valid, w_req_ready, w_imm_en_b, w_wb_valid, w_op_valid, w_op_ready, w_op_err;
    logic [7:0]   w_sel_a, w_sel_b, w_wb_sel;
    logic [15:0]  w_imm, w_wb_data, w_da, w_db;
    logic [127:0] w_rf_data;

    int checks = 0;
    int errors = 0;

    // Model of the held pair. A source of -1 means the operand has no register source.
    bit       m_valid;
    bit       m_err;
    logic [7:0] m_da, m_db;
    int       m_a_src, m_b_src;

    alu_operand_fetch #(.DATA_W(8), .NREG(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .sel_a(sel_a), .sel_b(sel_b), .imm_en_b(imm_en_b), .imm(imm),
        .rf_data(rf_data),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .da(da), .db(db), .op_err(op_err)
    );

    alu_operand_fetch #(.DATA_W(16), .NREG(8)) u_dut_wide (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready),
        .sel_a(w_sel_a), .sel_b(w_sel_b), .imm_en_b(w_imm_en_b), .imm(w_imm),
        .rf_data(w_rf_data),
        .wb_valid(w_wb_valid), .wb_sel(w_wb_sel), .wb_data(w_wb_data),
        .op_valid(w_op_valid), .op_ready(w_op_ready),
        .da(w_da), .db(w_db), .op_err(w_op_err)
    );

    // Index of the lowest set bit, found by isolating that bit arithmetically.
    // Returns -1 for an empty vector.
    function automatic int low_index(input logic [3:0] v);
        logic [3:0] lo;
        if (v == 4'd0) return -1;
        lo = v & (~v + 4'd1);
        return $clog2(lo);
    endfunction

    // One clock edge for the narrow instance, with the model advanced in step.
    // The task ends at posedge+1, when the registered outputs can be sampled.
    task automatic tick();
        int wbi, ai, bi;
        logic [7:0] av, bv;
        bit cap, err;
        wbi = wb_valid ? low_index(wb_sel) : -1;
        cap = req_valid && (!m_valid || op_ready);
        ai  = low_index(sel_a);
        av  = (ai < 0) ? 8'h00 : ((ai == wbi) ? wb_data : rf_data[ai*8 +: 8]);
        if (imm_en_b) begin
            bi = -1;
            bv = imm;
        end else begin
            bi = low_index(sel_b);
            bv = (bi < 0) ? 8'h00 : ((bi == wbi) ? wb_data : rf_data[bi*8 +: 8]);
        end
        err = (sel_a == 4'd0) || (sel_b == 4'd0 && !imm_en_b);
        @(posedge clk);
        if (cap) begin
            m_valid = 1; m_da = av; m_db = bv; m_a_src = ai; m_b_src = bi; m_err = err;
        end else if (m_valid && op_ready) begin
            m_valid = 0;
        end else if (m_valid && wbi >= 0) begin
            if (m_a_src == wbi) m_da = wb_data;
            if (m_b_src == wbi) m_db = wb_data;
        end
        #1;
    endtask

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_da = 0; m_db = 0; m_a_src = -1; m_b_src = -1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        req_valid = 0; sel_a = 0; sel_b = 0; imm_en_b = 0; imm = 0; rf_data = 0;
        wb_valid = 0; wb_sel = 0; wb_data = 0; op_ready = 1;
        w_req_valid = 0; w_sel_a = 0; w_sel_b = 0; w_imm_en_b = 0; w_imm = 0; w_rf_data = 0;
        w_wb_valid = 0; w_wb_sel = 0; w_wb_data = 0; w_op_ready = 1;
        model_reset();
        #3;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b exp 0", op_valid); end
        checks++; if (da !== 8'h00 || db !== 8'h00) begin errors++; $display("FAIL reset_data got %h/%h exp 00/00", da, db); end
        checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL reset_op_err got %b exp 0", op_err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (w_op_valid !== 1'b0) begin errors++; $display("FAIL reset_wide_op_valid got %b exp 0", w_op_valid); end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        $display("reset: op_valid=%b req_ready=%b", op_valid, req_ready);
    endtask

    task automatic test_basic();
        rf_data = 32'h44332211; sel_a = 4'b0100; sel_b = 4'b1010; imm_en_b = 0;
        req_valid = 1; op_ready = 1; wb_valid = 0; wb_sel = 0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_req_ready got %b exp 1", req_ready); end
        tick();
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL basic_op_valid got %b exp 1", op_valid); end
        checks++; if (da !== 8'h33 || db !== 8'h22) begin errors++; $display("FAIL basic_data got %h/%h exp 33/22", da, db); end
        checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL basic_op_err got %b exp 0", op_err); end
        $display("basic: da=%h db=%h err=%b", da, db, op_err);
    endtask

    task automatic test_forward();
        wb_valid = 1; wb_sel = 4'b0100; wb_data = 8'hA5;
        tick();
        checks++; if (da !== 8'hA5 || db !== 8'h22) begin errors++; $display("FAIL forward_data got %h/%h exp a5/22", da, db); end
        $display("forward: da=%h db=%h", da, db);
    endtask

    task automatic test_hold_refresh();
        sel_a = 4'b0010; sel_b = 4'b0000; imm_en_b = 1; imm = 8'h09;
        wb_valid = 0; req_valid = 1; op_ready = 1;
        tick();
        checks++; if (da !== 8'h22 || db !== 8'h09) begin errors++; $display("FAIL hold_capture got %h/%h exp 22/09", da, db); end
        req_valid = 0; op_ready = 0; wb_valid = 1; wb_sel = 4'b0010; wb_data = 8'h7E;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready got %b exp 0", req_ready); end
        tick();
        checks++; if (da !== 8'h7E || db !== 8'h09) begin errors++; $display("FAIL hold_refresh got %h/%h exp 7e/09", da, db); end
        // A write to another register, and a later rf change, do not reach the held pair.
        wb_sel = 4'b0001; wb_data = 8'h55; rf_data = 32'h444433EE;
        tick();
        checks++; if (da !== 8'h7E || db !== 8'h09) begin errors++; $display("FAIL hold_other_reg got %h/%h exp 7e/09", da, db); end
        // With two bits set, the lowest bit (R1) is the write target.
        wb_sel = 4'b1010; wb_data = 8'h3C;
        tick();
        checks++; if (da !== 8'h3C || db !== 8'h09) begin errors++; $display("FAIL hold_wb_priority got %h/%h exp 3c/09", da, db); end
        checks++; if (op_valid !== 1'b1 || op_err !== 1'b0) begin errors++; $display("FAIL hold_status got %b/%b exp 1/0", op_valid, op_err); end
        wb_valid = 0; op_ready = 1;
        tick();
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got %b exp 0", op_valid); end
        $display("hold_refresh: final da=%h db=%h", da, db);
    endtask

    task automatic test_back_to_back();
        logic [15:0] got[$];
        logic [15:0] exp_pairs [3];
        exp_pairs[0] = 16'hA1B2; exp_pairs[1] = 16'h5CD4; exp_pairs[2] = 16'hB2A1;
        rf_data = 32'hD4C3B2A1; imm_en_b = 0; wb_valid = 0; wb_sel = 0;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin req_valid = 1; sel_a = 4'b0001; sel_b = 4'b0010; op_ready = 1; end
                1: begin req_valid = 1; sel_a = 4'b0100; sel_b = 4'b1000; op_ready = 1; end
                2: begin req_valid = 1; sel_a = 4'b0010; sel_b = 4'b0001; op_ready = 0;
                         wb_valid = 1; wb_sel = 4'b0100; wb_data = 8'h5C; end
                3: begin op_ready = 1; wb_data = 8'h6D; end
                default: begin req_valid = 0; wb_valid = 0; op_ready = 1; end
            endcase
            #1;
            checks++;
            if (req_ready !== (!m_valid || op_ready)) begin
                errors++; $display("FAIL b2b_req_ready cycle %0d got %b exp %b", c, req_ready, (!m_valid || op_ready));
            end
            if (op_valid && op_ready) got.push_back({da, db});
            tick();
            checks++;
            if (op_valid !== m_valid || (m_valid && (da !== m_da || db !== m_db))) begin
                errors++; $display("FAIL b2b_pair cycle %0d got %b %h/%h exp %b %h/%h", c, op_valid, da, db, m_valid, m_da, m_db);
            end
            $display("b2b cycle %0d: op_valid=%b da=%h db=%h", c, op_valid, da, db);
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_pairs[i]) begin errors++; $display("FAIL b2b_order %0d got %h exp %h", i, got[i], exp_pairs[i]); end
        end
    endtask

    task automatic test_error();
        rf_data = 32'h44332211; req_valid = 1; op_ready = 1; wb_valid = 0;
        sel_a = 4'b0000; sel_b = 4'b0010; imm_en_b = 0;
        tick();
        checks++; if (da !== 8'h00 || db !== 8'h22 || op_err !== 1'b1) begin errors++; $display("FAIL err_sel_a got %h/%h/%b exp 00/22/1", da, db, op_err); end
        sel_a = 4'b0001; sel_b = 4'b0000; imm_en_b = 1; imm = 8'h5A;
        tick();
        checks++; if (da !== 8'h11 || db !== 8'h5A || op_err !== 1'b0) begin errors++; $display("FAIL err_imm got %h/%h/%b exp 11/5a/0", da, db, op_err); end
        imm_en_b = 0;
        tick();
        checks++; if (db !== 8'h00 || op_err !== 1'b1) begin errors++; $display("FAIL err_sel_b got %h/%b exp 00/1", db, op_err); end
        // An empty A select must never pick up a writeback while held.
        sel_a = 4'b0000; imm_en_b = 1; imm = 8'h00;
        tick();
        req_valid = 0; op_ready = 0; wb_valid = 1; wb_sel = 4'b0001; wb_data = 8'hFF;
        tick();
        checks++; if (da !== 8'h00 || db !== 8'h00 || op_err !== 1'b1) begin errors++; $display("FAIL err_no_refresh got %h/%h/%b exp 00/00/1", da, db, op_err); end
        wb_valid = 0; op_ready = 1;
        tick();
        $display("error: done, op_valid=%b", op_valid);
    endtask

    task automatic test_wide();
        for (int i = 0; i < 8; i++) w_rf_data[i*16 +: 16] = 16'(i * 16'h1111);
        w_rf_data[7*16 +: 16] = 16'hBEEF;
        w_rf_data[6*16 +: 16] = 16'hCAFE;
        w_sel_a = 8'h80; w_sel_b = 8'h00; w_imm_en_b = 1; w_imm = 16'h1234;
        w_req_valid = 1; w_op_ready = 1; w_wb_valid = 0;
        @(posedge clk); #1;
        checks++; if (w_op_valid !== 1'b1 || w_da !== 16'hBEEF || w_db !== 16'h1234 || w_op_err !== 1'b0) begin
            errors++; $display("FAIL wide_r7 got %b %h/%h/%b exp 1 beef/1234/0", w_op_valid, w_da, w_db, w_op_err); end
        w_sel_a = 8'h00; w_sel_b = 8'hC0; w_imm_en_b = 0;
        @(posedge clk); #1;
        checks++; if (w_da !== 16'h0000 || w_db !== 16'hCAFE || w_op_err !== 1'b1) begin
            errors++; $display("FAIL wide_err got %h/%h/%b exp 0000/cafe/1", w_da, w_db, w_op_err); end
        w_sel_a = 8'h80; w_wb_valid = 1; w_wb_sel = 8'h80; w_wb_data = 16'h7777;
        @(posedge clk); #1;
        checks++; if (w_da !== 16'h7777) begin errors++; $display("FAIL wide_forward got %h exp 7777", w_da); end
        w_req_valid = 0; w_op_ready = 0; w_wb_data = 16'h1357;
        @(posedge clk); #1;
        checks++; if (w_da !== 16'h1357 || w_db !== 16'hCAFE) begin errors++; $display("FAIL wide_refresh got %h/%h exp 1357/cafe", w_da, w_db); end
        w_wb_valid = 0; w_op_ready = 1;
        @(posedge clk); #1;
        $display("wide: op_valid=%b", w_op_valid);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rf_data   = $urandom;
            sel_a     = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            sel_b     = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            imm_en_b  = ($urandom_range(0, 3) == 0);
            imm       = 8'($urandom);
            wb_valid  = 1'($urandom);
            wb_sel    = 4'($urandom);
            wb_data   = 8'($urandom);
            req_valid = ($urandom_range(0, 3) != 0);
            op_ready  = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (req_ready !== (!m_valid || op_ready)) begin
                errors++; $display("FAIL rand_req_ready iter %0d got %b exp %b", n, req_ready, (!m_valid || op_ready));
            end
            tick();
            checks++;
            if (op_valid !== m_valid) begin
                errors++; $display("FAIL rand_op_valid iter %0d got %b exp %b", n, op_valid, m_valid);
            end else if (m_valid && (da !== m_da || db !== m_db || op_err !== m_err)) begin
                errors++; $display("FAIL rand_pair iter %0d got %h/%h/%b exp %h/%h/%b", n, da, db, op_err, m_da, m_db, m_err);
            end
        end
        req_valid = 0; wb_valid = 0; op_ready = 1;
        tick();
        $display("random: 400 cycles, op_valid=%b", op_valid);
    endtask

    task automatic test_reset_mid();
        rf_data = 32'h44332211; sel_a = 4'b0100; sel_b = 4'b1000; imm_en_b = 0;
        req_valid = 1; op_ready = 0; wb_valid = 0;
        w_sel_a = 8'h80; w_imm_en_b = 1; w_req_valid = 1; w_op_ready = 0;
        tick();
        checks++; if (op_valid !== 1'b1 || da !== 8'h33) begin errors++; $display("FAIL mid_full got %b %h exp 1 33", op_valid, da); end
        req_valid = 0; w_req_valid = 0;
        rst_n = 0;
        #1;
        model_reset();
        checks++; if (op_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_status got %b/%b exp 0/1", op_valid, req_ready); end
        checks++; if (da !== 8'h00 || db !== 8'h00 || op_err !== 1'b0) begin errors++; $display("FAIL mid_reset_data got %h/%h/%b exp 00/00/0", da, db, op_err); end
        checks++; if (w_op_valid !== 1'b0 || w_da !== 16'h0000) begin errors++; $display("FAIL mid_reset_wide got %b/%h exp 0/0000", w_op_valid, w_da); end
        @(posedge clk); #1;
        rst_n = 1;
        tick();
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL mid_after_release got %b exp 0", op_valid); end
        $display("reset_mid: op_valid=%b req_ready=%b", op_valid, req_ready);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_hold_refresh();
        test_back_to_back();
        test_error();
        test_wide();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
